// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard and pending-write counter.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module regfile_sb #(
    parameter int unsigned N = 64,
    parameter int unsigned A = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] ra1,
    input  logic [A-1:0] ra2,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    input  logic         we3,
    input  logic [A-1:0] wa3,
    input  logic [N-1:0] wd3,
    input  logic         rsv,
    input  logic [A-1:0] rsv_a,
    output logic         busy1,
    output logic         busy2,
    output logic [A:0]   npend
);

    localparam int unsigned DEPTH = 2**A;
    localparam logic [A-1:0] ZR = A'(DEPTH - 1);

    logic [N-1:0]     r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [A:0]       r_npend;

    logic             w_wr_ok;
    logic             w_rsv_ok;
    logic             w_inc;
    logic             w_dec;
    logic [DEPTH-1:0] w_busy_nxt;

    assign w_wr_ok  = we3 && (wa3 != ZR);
    assign w_rsv_ok = rsv && (rsv_a != ZR);
    assign w_inc    = w_rsv_ok && !r_busy[rsv_a];
    // A same-address reserve keeps the bit set, so the write must not count down
    assign w_dec    = w_wr_ok && r_busy[wa3] && !(w_rsv_ok && (rsv_a == wa3));

    // Write clears first, reserve sets afterwards so the reserve wins on a tie
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wa3] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_busy_nxt[rsv_a] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= N'(i);
            end
        end else if (w_wr_ok) begin
            r_regs[wa3] <= wd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= '0;
            r_npend <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_inc && !w_dec) begin
                r_npend <= r_npend + (A+1)'(1);
            end else if (w_dec && !w_inc) begin
                r_npend <= r_npend - (A+1)'(1);
            end
        end
    end

    assign npend = r_npend;

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;
    logic w_rsv_same1;
    logic w_rsv_same2;

    assign w_fwd1      = we3 && (wa3 == ra1) && (ra1 != ZR);
    assign w_fwd2      = we3 && (wa3 == ra2) && (ra2 != ZR);
    assign w_rsv_same1 = rsv && (rsv_a == ra1);
    assign w_rsv_same2 = rsv && (rsv_a == ra2);

    always_comb begin
        rd1   = (ra1 == ZR) ? '0 : r_regs[ra1];
        rd2   = (ra2 == ZR) ? '0 : r_regs[ra2];
        busy1 = (ra1 != ZR) && r_busy[ra1];
        busy2 = (ra2 != ZR) && r_busy[ra2];
        if (w_fwd1) begin
            rd1 = wd3;
            if (!w_rsv_same1) begin
                busy1 = 1'b0;
            end
        end
        if (w_fwd2) begin
            rd2 = wd3;
            if (!w_rsv_same2) begin
                busy2 = 1'b0;
            end
        end
    end
`else
    always_comb begin
        rd1   = (ra1 == ZR) ? '0 : r_regs[ra1];
        rd2   = (ra2 == ZR) ? '0 : r_regs[ra2];
        busy1 = (ra1 != ZR) && r_busy[ra1];
        busy2 = (ra2 != ZR) && r_busy[ra2];
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (N=64, A=5).
`timescale 1ns/1ps
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1, ra2;
    logic [63:0] rd1, rd2;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic        rsv;
    logic [4:0]  rsv_a;
    logic        busy1, busy2;
    logic [5:0]  npend;

    int checks   = 0;
    int failures = 0;

    regfile_sb #(.N(64), .A(5)) dut (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we3   (we3),
        .wa3   (wa3),
        .wd3   (wd3),
        .rsv   (rsv),
        .rsv_a (rsv_a),
        .busy1 (busy1),
        .busy2 (busy2),
        .npend (npend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we3 = 1'b0; rsv = 1'b0; wa3 = '0; wd3 = '0; rsv_a = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            logic [63:0] exp;
            ra1 = 5'(i); ra2 = 5'(i);
            #1;
            exp = (i == 31) ? 64'd0 : 64'(i);
            checks++;
            if (rd1 !== exp || rd2 !== exp) begin
                failures++;
                $display("FAIL reset_read[%0d] rd1=%h rd2=%h required=%h", i, rd1, rd2, exp);
            end
            checks++;
            if (busy1 !== 1'b0 || busy2 !== 1'b0 || npend !== 6'd0) begin
                failures++;
                $display("FAIL reset_busy[%0d] busy1=%b busy2=%b npend=%0d required 0/0/0", i, busy1, busy2, npend);
            end
        end
    endtask

    task automatic test_reserve();
        logic [4:0] seq [4];
        seq[0] = 5'd3; seq[1] = 5'd7; seq[2] = 5'd7; seq[3] = 5'd31;
        for (int i = 0; i < 4; i++) begin
            rsv = 1'b1; rsv_a = seq[i];
            tick();
        end
        idle();
        ra1 = 5'd3; ra2 = 5'd7;
        #1;
        checks++;
        if (npend !== 6'd2) begin
            failures++;
            $display("FAIL reserve_npend npend=%0d required=2", npend);
        end
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            failures++;
            $display("FAIL reserve_busy busy3=%b busy7=%b required 1/1", busy1, busy2);
        end
        ra1 = 5'd31; ra2 = 5'd4;
        #1;
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL reserve_zr busy31=%b busy4=%b required 0/0", busy1, busy2);
        end
    endtask

    task automatic test_write_clear();
        ra1 = 5'd7; ra2 = 5'd3;
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hDEAD_BEEF;
        #1;
`ifndef REGFILE_BYPASS_EN
        checks++;
        if (rd1 !== 64'd7 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL write_before_edge rd7=%h busy7=%b required 7/1", rd1, busy1);
        end
`endif
        tick();
        idle();
        #1;
        checks++;
        if (rd1 !== 64'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_data rd7=%h required=deadbeef", rd1);
        end
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b1 || npend !== 6'd1) begin
            failures++;
            $display("FAIL write_clear busy7=%b busy3=%b npend=%0d required 0/1/1", busy1, busy2, npend);
        end
    endtask

    task automatic test_same_edge();
        rsv = 1'b1; rsv_a = 5'd5;
        we3 = 1'b1; wa3 = 5'd5; wd3 = 64'h55;
        tick();
        idle();
        ra1 = 5'd5;
        #1;
        checks++;
        if (rd1 !== 64'h55 || busy1 !== 1'b1 || npend !== 6'd2) begin
            failures++;
            $display("FAIL same_addr rd5=%h busy5=%b npend=%0d required 55/1/2", rd1, busy1, npend);
        end
        // Reserve X8 while X3 is written back: net zero on npend
        rsv = 1'b1; rsv_a = 5'd8;
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h33;
        tick();
        idle();
        ra1 = 5'd3; ra2 = 5'd8;
        #1;
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b1 || npend !== 6'd2 || rd1 !== 64'h33) begin
            failures++;
            $display("FAIL diff_addr busy3=%b busy8=%b npend=%0d rd3=%h required 0/1/2/33", busy1, busy2, npend, rd1);
        end
        rsv = 1'b1; rsv_a = 5'd5;
        tick();
        idle();
        ra1 = 5'd5;
        #1;
        checks++;
        if (busy1 !== 1'b1 || npend !== 6'd2) begin
            failures++;
            $display("FAIL rereserve busy5=%b npend=%0d required 1/2", busy1, npend);
        end
        we3 = 1'b1; wa3 = 5'd10; wd3 = 64'hA0A0;
        tick();
        idle();
        ra1 = 5'd10;
        #1;
        checks++;
        if (rd1 !== 64'hA0A0 || busy1 !== 1'b0 || npend !== 6'd2) begin
            failures++;
            $display("FAIL write_idle rd10=%h busy10=%b npend=%0d required a0a0/0/2", rd1, busy1, npend);
        end
    endtask

    task automatic test_zr_write();
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hFFFF;
        tick();
        idle();
        ra1 = 5'd31; ra2 = 5'd31;
        #1;
        checks++;
        if (rd1 !== 64'd0 || rd2 !== 64'd0 || npend !== 6'd2 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL zr_write rd31=%h rd31b=%h npend=%0d busy31=%b required 0/0/2/0", rd1, rd2, npend, busy1);
        end
`ifdef REGFILE_BYPASS_EN
        ra1 = 5'd9; we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h1234;
        #1;
        checks++;
        if (rd1 !== 64'h1234) begin
            failures++;
            $display("FAIL bypass rd1=%h required=1234", rd1);
        end
        tick();
        idle();
`endif
    endtask

    task automatic test_async_reset();
        rsv = 1'b1; rsv_a = 5'd1;
        tick();
        rsv_a = 5'd2;
        tick();
        idle();
        ra1 = 5'd1; ra2 = 5'd2;
        #1;
        checks++;
        if (npend !== 6'd4 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset npend=%0d busy1=%b busy2=%b required 4/1/1", npend, busy1, busy2);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (npend !== 6'd0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_busy npend=%0d busy1=%b busy2=%b required 0/0/0", npend, busy1, busy2);
        end
        checks++;
        if (rd1 !== 64'd1 || rd2 !== 64'd2) begin
            failures++;
            $display("FAIL async_reset_data rd1=%h rd2=%h required 1/2", rd1, rd2);
        end
        ra1 = 5'd7; ra2 = 5'd5;
        #1;
        checks++;
        if (rd1 !== 64'd7 || rd2 !== 64'd5) begin
            failures++;
            $display("FAIL async_reset_restore rd7=%h rd5=%h required 7/5", rd1, rd2);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ra1 = '0; ra2 = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        test_reserve();
        test_write_clear();
        test_same_edge();
        test_zr_write();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
